// File: rtl/par2ser.sv
// Parallel-to-serial unpacker: each accepted N-element word leaves as N WIDTH-bit
// beats, top slice first, with a one-word prefetch buffer for gapless output.
module par2ser #(
   parameter  int WIDTH = 16,
   parameter  int N     = 4,
   localparam int CW    = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ivalid,
   output logic               iready,
   input  logic [N*WIDTH-1:0] in,
   output logic               ovalid,
   input  logic               oready,
   output logic [WIDTH-1:0]   out,
   output logic               olast,
   output logic [CW-1:0]      oidx
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [N*WIDTH-1:0] sr_q, sr_d;
   logic [N*WIDTH-1:0] pbuf_q, pbuf_d;
   logic               pvalid_q, pvalid_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic accept_s;
   logic beat_s;
   logic last_s;

   assign iready   = ~pvalid_q;
   assign ovalid   = (state_q == ST_SEND);
   assign out      = sr_q[N*WIDTH-1 -: WIDTH];
   assign oidx     = cnt_q;
   assign last_s   = (cnt_q == CW'(N - 1));
   assign olast    = ovalid & last_s;
   assign accept_s = ivalid & iready;
   assign beat_s   = ovalid & oready;

   // State register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sr_q     <= '0;
         pbuf_q   <= '0;
         pvalid_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         pbuf_q   <= pbuf_d;
         pvalid_q <= pvalid_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state logic for the shift register, beat index and prefetch buffer.
   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      pbuf_d   = pbuf_q;
      pvalid_d = pvalid_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               sr_d    = in;
               cnt_d   = '0;
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (beat_s && last_s) begin
               // Word finishes: reload from prefetch or input without a bubble.
               cnt_d = '0;
               if (pvalid_q) begin
                  sr_d     = pbuf_q;
                  pvalid_d = 1'b0;
               end else if (accept_s) begin
                  sr_d = in;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               if (beat_s) begin
                  sr_d  = sr_q << WIDTH;
                  cnt_d = cnt_q + CW'(1);
               end else begin
                  sr_d  = sr_q;
               end
               if (accept_s) begin
                  pbuf_d   = in;
                  pvalid_d = 1'b1;
               end else begin
                  pvalid_d = pvalid_q;
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            pvalid_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_par2ser.sv
// Randomized scoreboard bench for par2ser: accepted words are expanded into
// expected beats by a queue model and a monitor checks every presented beat.
module tb_par2ser;
   localparam int WIDTH = 16;
   localparam int N     = 4;
   localparam int CW    = $clog2(N);

   logic               clk = 1'b0;
   logic               rst;
   logic               ivalid;
   logic               iready;
   logic [N*WIDTH-1:0] in_w;
   logic               ovalid;
   logic               oready;
   logic [WIDTH-1:0]   out_w;
   logic               olast;
   logic [CW-1:0]      oidx;

   typedef struct {
      logic [WIDTH-1:0] d;
      int               idx;
      bit               last;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    passes = 0;
   bit    acc_flag = 1'b0;
   bit    mon_en = 1'b0;

   par2ser #(.WIDTH(WIDTH), .N(N)) dut (
      .clk(clk), .rst(rst),
      .ivalid(ivalid), .iready(iready), .in(in_w),
      .ovalid(ovalid), .oready(oready), .out(out_w),
      .olast(olast), .oidx(oidx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   // Reference model: a word becomes N beats, most significant element first.
   function automatic void push_word(input logic [N*WIDTH-1:0] w);
      for (int i = 0; i < N; i++) begin
         beat_t b;
         b.d    = w[N*WIDTH-1-i*WIDTH -: WIDTH];
         b.idx  = i;
         b.last = (i == N-1);
         exp_q.push_back(b);
      end
   endfunction

   // Monitor: samples just before each rising edge, when handshakes are settled.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         acc_flag = 1'b0;
         if (mon_en && !rst) begin
            check("ovalid", ovalid, exp_q.size() != 0);
            check("iready", iready, exp_q.size() <= N);
            if (ovalid && exp_q.size() != 0) begin
               check("out",   out_w, exp_q[0].d);
               check("oidx",  oidx,  exp_q[0].idx);
               check("olast", olast, exp_q[0].last);
               if (oready) void'(exp_q.pop_front());
            end
            if (ivalid && iready) begin
               push_word(in_w);
               acc_flag = 1'b1;
            end
         end
      end
   end

   // Drive random traffic; a presented word is held until accepted.
   task automatic run(input int cycles, input int vpct, input int rpct);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (acc_flag || !ivalid) begin
            ivalid = ($urandom_range(0, 99) < vpct);
            in_w   = {$urandom, $urandom};
         end
         oready = ($urandom_range(0, 99) < rpct);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst    = 1'b1;
      ivalid = 1'b0;
      oready = 1'b0;
      in_w   = '0;
      #12;
      check("rst_ovalid", ovalid, 1'b0);
      check("rst_olast",  olast,  1'b0);
      check("rst_iready", iready, 1'b1);
      check("rst_out",    out_w,  '0);
      check("rst_oidx",   oidx,   '0);
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Single known word, then idle long enough to see ovalid drop.
      @(negedge clk);
      in_w   = 64'h0004_0003_0002_0001;
      ivalid = 1'b1;
      oready = 1'b1;
      run(8, 0, 100);

      run(40, 100, 100);
      run(400, 50, 70);
      run(300, 80, 30);
      run(20, 100, 100);

      // Asynchronous reset in the middle of a busy stream.
      @(negedge clk);
      check("pre_rst_busy", ovalid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_ovalid", ovalid, 1'b0);
      check("mid_rst_olast",  olast,  1'b0);
      check("mid_rst_iready", iready, 1'b1);
      check("mid_rst_out",    out_w,  '0);
      check("mid_rst_oidx",   oidx,   '0);
      exp_q.delete();
      ivalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run(60, 60, 80);

      // Drain with a bounded wait.
      @(negedge clk);
      ivalid = 1'b0;
      oready = 1'b1;
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
      check("drain_empty", exp_q.size(), 0);
      @(negedge clk);
      check("drain_ovalid", ovalid, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
